pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 14 +
 rtl/pipeline_ctrl_hazard_detect.sv | 17 +
 rtl/pipeline_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline hazard/stall controller: state encoding and field widths.
package pipeline_ctrl_pkg;

  localparam int REG_W   = 5;
  localparam int STALL_W = 16;
  localparam int STATE_W = 2;
  localparam int WAIT_W  = 8;
  localparam int FLUSH_W = 2;

  localparam logic [STATE_W-1:0] ST_RUN      = 2'd0;
  localparam logic [STATE_W-1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [STATE_W-1:0] ST_FLUSH    = 2'd2;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard comparator: the load in EX writes a register the ID instruction reads.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs2,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rd,
  output logic             load_use
);

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign load_use = idex_memread && (idex_rd != {REG_W{1'b0}}) &&
                    ((idex_rd == id_rs1) || (id_uses_rs2 && (idex_rd == id_rs2)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control FSM: memory-stall, branch-flush and load-use priority mux plus stall statistics.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int FLUSH_CYC = 1,
  parameter int MAX_WAIT  = 15
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic [REG_W-1:0]   id_rs1,
  input  logic [REG_W-1:0]   id_rs2,
  input  logic               id_uses_rs2,
  input  logic               idex_memread,
  input  logic [REG_W-1:0]   idex_rd,
  input  logic               branch_taken,
  input  logic               dmem_req,
  input  logic               dmem_ready,
  output logic               pc_en,
  output logic               ifid_en,
  output logic               idex_en,
  output logic               exmem_en,
  output logic               memwb_en,
  output logic               ifid_flush,
  output logic               idex_bubble,
  output logic               mem_timeout,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam logic               FLUSH_MULTI = (FLUSH_CYC > 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LOAD  = FLUSH_W'(FLUSH_CYC - 1);
  localparam logic [WAIT_W-1:0]  WAIT_LIMIT  = WAIT_W'(MAX_WAIT);

  logic [STATE_W-1:0] state_r, state_nxt_s;
  logic [WAIT_W-1:0]  wait_cnt_r, wait_nxt_s;
  logic [FLUSH_W-1:0] flush_cnt_r, flush_nxt_s;
  logic               timeout_r;
  logic [STALL_W-1:0] stall_cnt_r;
  logic               load_use_s;

  hazard_detect u_hazard (
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs2  (id_uses_rs2),
    .idex_memread (idex_memread),
    .idex_rd      (idex_rd),
    .load_use     (load_use_s)
  );

  // Priority mux: reset > memory stall > taken branch > load-use; outputs act in the same cycle
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    state_nxt_s = state_r;
    if (!arst_n) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_nxt_s = ST_RUN;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (dmem_req && !dmem_ready) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
            state_nxt_s = ST_MEM_WAIT;
          end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_nxt_s = FLUSH_MULTI ? ST_FLUSH : ST_RUN;
          end else if (load_use_s) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_MEM_WAIT: begin
          if (!dmem_ready) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
          end else if (branch_taken) begin
            // branch held in EX across the stall is resolved on the ready cycle
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_nxt_s = FLUSH_MULTI ? ST_FLUSH : ST_RUN;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_FLUSH: begin
          ifid_flush = 1'b1;
          if (flush_cnt_r <= 2'd1) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_FLUSH;
          end
        end
        default: begin
          state_nxt_s = ST_RUN;
        end
      endcase
    end
  end

  // Wait counter numbers the current MEM_WAIT cycle; flush counter holds remaining FLUSH cycles
  always_comb begin
    wait_nxt_s  = {WAIT_W{1'b0}};
    flush_nxt_s = {FLUSH_W{1'b0}};
    if (state_nxt_s == ST_MEM_WAIT) begin
      wait_nxt_s = (wait_cnt_r == WAIT_LIMIT) ? wait_cnt_r : wait_cnt_r + 8'd1;
    end else begin
      wait_nxt_s = {WAIT_W{1'b0}};
    end
    if (state_nxt_s == ST_FLUSH) begin
      flush_nxt_s = (state_r == ST_FLUSH) ? flush_cnt_r - 2'd1 : FLUSH_LOAD;
    end else begin
      flush_nxt_s = {FLUSH_W{1'b0}};
    end
  end

  // State, counters, sticky timeout and saturating stall statistics
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_r     <= ST_RUN;
      wait_cnt_r  <= {WAIT_W{1'b0}};
      flush_cnt_r <= {FLUSH_W{1'b0}};
      timeout_r   <= 1'b0;
      stall_cnt_r <= {STALL_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      wait_cnt_r  <= wait_nxt_s;
      flush_cnt_r <= flush_nxt_s;
      if ((state_nxt_s == ST_MEM_WAIT) && (wait_nxt_s == WAIT_LIMIT)) begin
        timeout_r <= 1'b1;
      end
      if (!pc_en && (stall_cnt_r != 16'hFFFF)) begin
        stall_cnt_r <= stall_cnt_r + 16'd1;
      end
    end
  end

  assign mem_timeout = timeout_r;
  assign stall_cnt   = stall_cnt_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a rule-level model queues expected outputs, a monitor compares.
module tb_pipeline_ctrl;

  localparam int FC = 2;
  localparam int MW = 15;

  typedef struct packed {
    logic [6:0]  ctl;     // {pc,ifid,idex,exmem,memwb,flush,bubble}
    logic        to;
    logic [15:0] sc;
    logic        regs_known;
  } exp_t;

  logic clk = 1'b0;
  logic arst_n, id_uses_rs2, idex_memread, branch_taken, dmem_req, dmem_ready;
  logic [4:0] id_rs1, id_rs2, idex_rd;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_bubble, mem_timeout;
  logic [15:0] stall_cnt;

  exp_t exp_q[$];
  int checks = 0;
  int passed = 0;

  // model state: plain counters expressing the rules
  bit m_known = 0;
  bit m_waiting = 0;
  int m_wait_num = 0;
  int m_flush_left = 0;
  bit m_timeout = 0;
  int m_stalls = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.FLUSH_CYC(FC), .MAX_WAIT(MW)) dut (
    .clk(clk), .arst_n(arst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .idex_memread(idex_memread), .idex_rd(idex_rd), .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_en(pc_en), .ifid_en(ifid_en),
    .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
  );

  task automatic cyc(input logic rst_i, input logic req_i, input logic rdy_i, input logic br_i,
                     input logic mr_i, input logic [4:0] rd_i, input logic [4:0] rs1_i,
                     input logic [4:0] rs2_i, input logic u2_i);
    exp_t e;
    bit lu;
    @(posedge clk);
    #1;
    arst_n = rst_i; dmem_req = req_i; dmem_ready = rdy_i; branch_taken = br_i;
    idex_memread = mr_i; idex_rd = rd_i; id_rs1 = rs1_i; id_rs2 = rs2_i; id_uses_rs2 = u2_i;
    e.to = m_timeout;
    e.sc = 16'(m_stalls);
    e.regs_known = m_known;
    lu = mr_i && (rd_i != 5'd0) && ((rd_i == rs1_i) || (u2_i && rd_i == rs2_i));
    if (!rst_i) begin
      e.ctl = 7'b0000011;
      m_known = 1; m_waiting = 0; m_wait_num = 0; m_flush_left = 0; m_timeout = 0; m_stalls = 0;
    end else begin
      if (m_flush_left > 0) begin
        e.ctl = 7'b1111110;
        m_flush_left--;
      end else if (m_waiting) begin
        if (!rdy_i) begin
          e.ctl = 7'b0000000;
          m_wait_num++;
        end else begin
          m_waiting = 0; m_wait_num = 0;
          e.ctl = br_i ? 7'b1111111 : 7'b1111100;
          if (br_i) m_flush_left = FC - 1;
        end
      end else if (req_i && !rdy_i) begin
        e.ctl = 7'b0000000;
        m_waiting = 1; m_wait_num = 1;
      end else if (br_i) begin
        e.ctl = 7'b1111111;
        m_flush_left = FC - 1;
      end else if (lu) begin
        e.ctl = 7'b0011101;
      end else begin
        e.ctl = 7'b1111100;
      end
      if (m_waiting && m_wait_num >= MW) m_timeout = 1;
      if (!e.ctl[6] && m_stalls < 65535) m_stalls++;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  // monitor: outputs are valid every cycle, compared mid-cycle against the queued expectation
  always @(negedge clk) begin
    exp_t e;
    logic [6:0] act;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_bubble};
      checks++;
      if (act === e.ctl) passed++;
      else $display("FAIL ctl t=%0t got=%b want=%b", $time, act, e.ctl);
      if (e.regs_known) begin
        checks++;
        if (mem_timeout === e.to) passed++;
        else $display("FAIL mem_timeout t=%0t got=%b want=%b", $time, mem_timeout, e.to);
        checks++;
        if (stall_cnt === e.sc) passed++;
        else $display("FAIL stall_cnt t=%0t got=%0d want=%0d", $time, stall_cnt, e.sc);
      end
    end
  end

  initial begin
    arst_n = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b1; branch_taken = 1'b0;
    idex_memread = 1'b0; idex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b0;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    idle(2);
    // load-use hit on rs1, then non-hazards (rd=0, rs2 unused), then rs2 hit
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
    idle(1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 5'd1, 5'd5, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 5'd1, 5'd5, 1'b1);
    // three-cycle memory stall
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    idle(1);
    // taken branch, and branch coincident with load-use
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    idle(2);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0);
    idle(2);
    // branch held during a memory stall
    for (int i = 0; i < 2; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    idle(2);
    // long stall for timeout, then reset in the middle of another stall
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    idle(2);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    idle(2);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 5),
          ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)),
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end
    idle(1);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain got=%0d pending want=0", exp_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
